// File: rtl/frame_switch_if.sv
// frame_switch_if: per-port FIFO handshake bundle for frame_switch.
// Port i occupies bit [i] of the 1-bit-per-port vectors and bits [9*i+8:9*i]
// of the 9-bit-per-port word vectors. Word format: [8]=1 byte, [8]=0 delimiter.
//   master (switch side): drives rd_en, wr_en, wr_data; samples rd_data, rd_empty, wr_full
//   slave  (FIFO side)  : the reverse
interface frame_switch_if #(
  parameter int unsigned NPORT = 2
);
  logic [NPORT-1:0]   rd_en;     // ingress FIFO pop
  logic [9*NPORT-1:0] rd_data;   // ingress head word (show-ahead)
  logic [NPORT-1:0]   rd_empty;  // ingress FIFO empty
  logic [NPORT-1:0]   wr_en;     // egress FIFO push
  logic [9*NPORT-1:0] wr_data;   // egress word
  logic [NPORT-1:0]   wr_full;   // egress almost-full (>=2 entries still free)

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output wr_en,
    output wr_data,
    input  wr_full
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  wr_en,
    input  wr_data,
    output wr_full
  );
endinterface

// File: rtl/frame_switch.sv
// frame_switch: N-port flooding frame forwarder between per-PHY rx read FIFOs
// and tx write FIFOs. A round-robin arbiter picks one ingress port with a
// pending frame and copies it word by word to every other port. Frames longer
// than MAX_FRAME bytes are cut with a synthesised delimiter and the remainder
// is drained; stray delimiters seen while idle are dropped.
//
// Ports:
//   sys_clk      system clock
//   sys_rstn     synchronous active-low reset
//   bus          frame_switch_if.master (rd_en/rd_data/rd_empty, wr_en/wr_data/wr_full)
//   truncated    one-cycle pulse, aligned with the synthesised delimiter push
//   stat_sel     statistics port select
//   stat_frames  frames forwarded from port stat_sel (registered)
//
// Build option: define FRAME_SWITCH_STATS_EN to build the per-port 32-bit
// frame counters; otherwise stat_frames is constant 0.
module frame_switch #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned MAX_FRAME = 1518
) (
  input  logic                     sys_clk,
  input  logic                     sys_rstn,
  frame_switch_if.master           bus,
  output logic                     truncated,
  input  logic [$clog2(NPORT)-1:0] stat_sel,
  output logic [31:0]              stat_frames
);

  localparam int unsigned PW = $clog2(NPORT);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      last_q, last_d;        // last granted port, also the FWD/DRAIN source
  logic [11:0]        len_q, len_d;
  logic               trunc_pend_q, trunc_pend_d;
  logic [NPORT-1:0]   wr_en_q, wr_en_d;
  logic [8:0]         wr_word_q, wr_word_d;
  logic               truncated_q, truncated_d;

  logic [NPORT-1:0]   rd_en_c;
  logic               count_frame;
  logic               drop;
  logic               grant;
  logic [PW:0]        cand;
  logic [8:0]         head [NPORT];
  logic [NPORT-1:0]   src_mask;
  logic [8:0]         src_head;
  logic               src_empty;
  logic               out_stall;

  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      head[i] = bus.rd_data[9*i +: 9];
    end
  end

  assign src_mask  = NPORT'(1) << last_q;
  assign src_head  = head[last_q];
  assign src_empty = bus.rd_empty[last_q];
  // The source's own egress FIFO never receives, so its almost-full is ignored.
  assign out_stall = |(bus.wr_full & ~src_mask);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    len_d        = len_q;
    trunc_pend_d = trunc_pend_q;
    wr_en_d      = '0;
    wr_word_d    = wr_word_q;
    truncated_d  = 1'b0;
    rd_en_c      = '0;
    count_frame  = 1'b0;
    drop         = 1'b0;
    grant        = 1'b0;
    cand         = '0;

    unique case (state_q)
      IDLE: begin
        // Stray delimiters take precedence over granting; lowest port first.
        for (int unsigned i = 0; i < NPORT; i++) begin
          if (!drop && !bus.rd_empty[i] && !head[i][8]) begin
            drop       = 1'b1;
            rd_en_c[i] = 1'b1;
          end
        end
        if (!drop) begin
          // Round-robin scan last+1, last+2, ... wrapping modulo NPORT.
          for (int unsigned k = 1; k <= NPORT; k++) begin
            cand = {1'b0, last_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NPORT)) begin
              cand = cand - (PW+1)'(NPORT);
            end
            if (!grant && !bus.rd_empty[cand[PW-1:0]]) begin
              grant  = 1'b1;
              last_d = cand[PW-1:0];
            end
          end
          if (grant) begin
            len_d        = '0;
            trunc_pend_d = 1'b0;
            state_d      = FWD;
          end
        end
      end

      FWD: begin
        if (trunc_pend_q) begin
          // Frame hit MAX_FRAME: emit a delimiter without popping the source.
          if (!out_stall) begin
            wr_en_d      = ~src_mask;
            wr_word_d    = '0;
            truncated_d  = 1'b1;
            count_frame  = 1'b1;
            trunc_pend_d = 1'b0;
            state_d      = DRAIN;
          end
        end else if (!src_empty && !out_stall) begin
          rd_en_c   = src_mask;
          wr_en_d   = ~src_mask;
          wr_word_d = src_head;
          if (src_head[8]) begin
            len_d = len_q + 12'd1;
            if (len_q + 12'd1 == 12'(MAX_FRAME)) begin
              trunc_pend_d = 1'b1;
            end
          end else begin
            count_frame = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      DRAIN: begin
        if (!src_empty) begin
          rd_en_c = src_mask;
          if (!src_head[8]) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_q      <= IDLE;
      last_q       <= PW'(NPORT - 1);
      len_q        <= '0;
      trunc_pend_q <= 1'b0;
      wr_en_q      <= '0;
      wr_word_q    <= '0;
      truncated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      len_q        <= len_d;
      trunc_pend_q <= trunc_pend_d;
      wr_en_q      <= wr_en_d;
      wr_word_q    <= wr_word_d;
      truncated_q  <= truncated_d;
    end
  end

  // Pops are combinational; hold them off while reset is asserted.
  assign bus.rd_en   = sys_rstn ? rd_en_c : '0;
  assign bus.wr_en   = wr_en_q;
  // Every egress sees the same word; only wr_en differs per port.
  assign bus.wr_data = {NPORT{wr_word_q}};
  assign truncated   = truncated_q;

`ifdef FRAME_SWITCH_STATS_EN
  logic [31:0] cnt_q [NPORT];
  logic [31:0] stat_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        cnt_q[i] <= '0;
      end
      stat_q <= '0;
    end else begin
      if (count_frame) begin
        cnt_q[last_q] <= cnt_q[last_q] + 32'd1;
      end
      stat_q <= cnt_q[stat_sel];
    end
  end

  assign stat_frames = stat_q;
`else
  logic stat_unused;
  assign stat_unused = ^{stat_sel, count_frame};
  assign stat_frames = '0;
`endif

endmodule

// File: tb/tb_frame_switch.sv
// tb_frame_switch: directed self-checking bench for frame_switch (4 ports,
// MAX_FRAME=64). Ingress FIFOs are bench queues; the expected egress stream of
// every port is built from the flooding/truncation rules as frames are queued.
module tb_frame_switch;

  localparam int unsigned NP   = 4;
  localparam int unsigned MAXF = 64;

`ifdef FRAME_SWITCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        truncated;
  logic [1:0]  stat_sel;
  logic [31:0] stat_frames;

  always #5 clk = ~clk;

  frame_switch_if #(.NPORT(NP)) bus ();

  frame_switch #(.NPORT(NP), .MAX_FRAME(MAXF)) dut (
    .sys_clk     (clk),
    .sys_rstn    (rstn),
    .bus         (bus),
    .truncated   (truncated),
    .stat_sel    (stat_sel),
    .stat_frames (stat_frames)
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  inq  [NP][$];
  logic [8:0]  expq [NP][$];
  int unsigned exp_frames [NP];
  int unsigned pops [NP];
  int unsigned exp_trunc  = 0;
  int unsigned trunc_seen = 0;
  logic [NP-1:0] full_v   = '0;
  logic [NP-1:0] pop_v    = '0;
  logic          pop_any  = 1'b0;
  logic [8:0]    pop_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue a frame on ingress port p and append what every other port must see.
  // Call order across ports must follow the expected round-robin order.
  task automatic send_frame(input int unsigned p, input int unsigned len, input int unsigned id);
    logic [8:0] b;
    for (int unsigned k = 0; k < len; k++) begin
      b = {1'b1, 8'((id*7 + k) % 256)};
      inq[p].push_back(b);
      if (k < MAXF) begin
        for (int unsigned q = 0; q < NP; q++) begin
          if (q != p) expq[q].push_back(b);
        end
      end
    end
    inq[p].push_back(9'h000);
    for (int unsigned q = 0; q < NP; q++) begin
      if (q != p) expq[q].push_back(9'h000);
    end
    if (len >= MAXF) exp_trunc++;
    exp_frames[p]++;
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      done = 1'b1;
      for (int unsigned p = 0; p < NP; p++) begin
        if (inq[p].size() != 0 || expq[p].size() != 0) done = 1'b0;
      end
    end
    chk(name, done, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Ingress model + output compare. Inputs change only here, at the falling
  // edge; registered outputs are checked first, then the combinational pop.
  always @(negedge clk) begin
    logic [8:0] w;
    for (int p = 0; p < NP; p++) begin
      if (pop_v[p] && inq[p].size() > 0) void'(inq[p].pop_front());
    end
    for (int p = 0; p < NP; p++) begin
      bus.rd_empty[p]         = (inq[p].size() == 0);
      bus.rd_data[9*p +: 9]   = (inq[p].size() > 0) ? inq[p][0] : 9'h000;
    end
    bus.wr_full = full_v;

    for (int p = 0; p < NP; p++) begin
      if (bus.wr_en[p]) begin
        w = bus.wr_data[9*p +: 9];
        if (expq[p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push port %0d: got word 0x%0h, want no push at %0t", p, w, $time);
        end else begin
          chk($sformatf("push_word_p%0d", p), w, expq[p].pop_front());
        end
        if (pop_any) begin
          chk("push_matches_pop", w, pop_word);
        end else begin
          chk("synth_delim_word", w, 9'h000);
          chk("synth_delim_trunc", truncated, 1'b1);
        end
      end
    end
    if (truncated) begin
      trunc_seen++;
      chk("trunc_with_push", |bus.wr_en, 1'b1);
      chk("trunc_without_pop", pop_any, 1'b0);
    end

    #1;
    pop_v = bus.rd_en;
    chk("rd_en_onehot", ($countones(pop_v) <= 1), 1'b1);
    pop_any = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (pop_v[p]) begin
        chk("pop_nonempty", (inq[p].size() > 0), 1'b1);
        if (inq[p].size() > 0) pop_word = inq[p][0];
        pop_any = 1'b1;
        pops[p]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int unsigned p1_0;
    int unsigned p2_0;
    for (int p = 0; p < NP; p++) begin
      exp_frames[p] = 0;
      pops[p] = 0;
    end
    rstn     = 1'b0;
    stat_sel = '0;
    full_v   = '0;
    // Stray delimiter already present while reset is held.
    inq[2].push_back(9'h000);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_rd_en", bus.rd_en, 4'b0000);
    chk("reset_wr_en", bus.wr_en, 4'b0000);
    chk("reset_wr_data", bus.wr_data, 36'h0);
    chk("reset_truncated", truncated, 1'b0);
    chk("reset_stat", stat_frames, 32'd0);

    // Stray delimiter popped in the first idle cycle, nothing pushed.
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk); #2;
    chk("stray_pop", bus.rd_en, 4'b0100);
    @(negedge clk); #2;
    chk("stray_once", bus.rd_en, 4'b0000);
    chk("stray_no_push", bus.wr_en, 4'b0000);

    // Ports 1 and 3 pending together: port 0 has first priority, so 1 then 3.
    @(posedge clk); #1;
    send_frame(1, 10, 1);
    send_frame(3, 12, 2);
    @(negedge clk); #2;
    chk("grant_cycle_rd_en", bus.rd_en, 4'b0000);
    @(negedge clk); #2;
    chk("first_pop_rd_en", bus.rd_en, 4'b0010);
    @(negedge clk); #2;
    chk("first_push_wr_en", bus.wr_en, 4'b1101);
    chk("first_push_word", bus.wr_data[8:0], 9'h107);
    wait_drain("drain_rr", 200);

    // Plain frame from port 0.
    send_frame(0, 20, 3);
    wait_drain("drain_p0", 200);

    // Stall from wr_full[2] mid-frame, then wr_full on the source (ignored).
    send_frame(0, 40, 4);
    repeat (6) @(posedge clk);
    #1;
    full_v = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk("stall_rd_en", bus.rd_en, 4'b0000);
      if (k > 0) chk("stall_wr_en", bus.wr_en, 4'b0000);
    end
    @(posedge clk); #1;
    full_v = 4'b0000;
    @(negedge clk); #2;
    chk("stall_last_wr_en", bus.wr_en, 4'b0000);
    chk("stall_resume", bus.rd_en, 4'b0001);
    @(posedge clk); #1;
    full_v = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      chk("src_full_ignored", bus.rd_en, 4'b0001);
    end
    @(posedge clk); #1;
    full_v = 4'b0000;
    wait_drain("drain_stall", 300);

    // Length limit: 63 (intact), 100 (cut), 64 (cut exactly at limit), 5.
    // last=0, so the arbiter alternates 1, 2, 1, 2.
    t0   = trunc_seen;
    p1_0 = pops[1];
    p2_0 = pops[2];
    send_frame(1, 63, 7);
    send_frame(2, 100, 5);
    send_frame(1, 64, 8);
    send_frame(2, 5, 6);
    wait_drain("drain_trunc", 1000);
    chk("trunc_count_model", trunc_seen, exp_trunc);
    chk("trunc_pulses", trunc_seen - t0, 2);
    chk("pops_port2", pops[2] - p2_0, 107);
    chk("pops_port1", pops[1] - p1_0, 129);

    // Per-port frame counters against the model.
    for (int p = 0; p < NP; p++) begin
      @(posedge clk); #1;
      stat_sel = 2'(p);
      @(posedge clk);
      @(negedge clk); #2;
      chk($sformatf("stat_port%0d", p), stat_frames, STATS ? exp_frames[p] : 0);
    end
    stat_sel = 2'd0;
    @(negedge clk); #2;
    chk("stat_port0_literal", stat_frames, STATS ? 32'd2 : 32'd0);

    // Counters restart from reset; three frames from port 0.
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int p = 0; p < NP; p++) exp_frames[p] = 0;
    send_frame(0, 4, 9);
    send_frame(0, 4, 10);
    send_frame(0, 4, 11);
    wait_drain("drain_stats", 200);
    @(negedge clk); #2;
    chk("stat_three", stat_frames, STATS ? 32'd3 : 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk); #2;
    chk("stat_after_reset", stat_frames, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk); #2;
    chk("stat_after_release", stat_frames, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
